iob_plic_src_filter: RTL and testbench
======================================

# iob_plic_src_filter

Interrupt-source conditioning stage that sits directly upstream of the PLIC's `src` input. Each raw, possibly asynchronous interrupt line passes through a multi-flop synchronizer and a programmable-length debounce filter. The block delivers clean, clock-aligned levels and edges to the PLIC gateways, so their edge/level logic never sees metastable or glitching inputs. Per-source bypass allows lines that are already synchronous to skip the filter.

## Interface
Parameters:
- `SOURCES`, 64, number of interrupt lines; must match the downstream PLIC.
- `SYNC_STAGES`, 2, synchronizer depth; legal values are 2..4.
- `FILTER_W`, 8, width of the debounce length and of each per-source counter.

Ports:
- `clk`  input  1  system clock; all state is on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `src_in`  input  SOURCES  raw interrupt lines; may be asynchronous.
- `bypass`  input  SOURCES  per-source filter bypass; quasi-static, synchronous to `clk`.
- `filter_len`  input  FILTER_W  number of consecutive stable cycles required; shared by all sources and synchronous to `clk`.
- `src_out`  output  SOURCES  conditioned lines; connects to the PLIC `src` input.
- `glitch`  output  SOURCES  one-cycle pulse when a pending change is rejected.

## Operation
- Synchronizer: each source uses a chain of `SYNC_STAGES` flops. `sync[i]` is the last stage of the chain. No logic sits between stages.
- Effective length: `L = max(filter_len, 1)`.
- Per-source state:
  - `stable[i]` is the registered output, so `src_out[i] = stable[i]`.
  - `cnt[i]` is a FILTER_W-bit counter.
- Filter rule, evaluated every edge for a non-bypassed source:
  - If `sync[i] != stable[i]` and `cnt[i] + 1 >= L`: `stable[i] <= sync[i]` and `cnt[i] <= 0`.
  - If `sync[i] != stable[i]` otherwise: `cnt[i] <= cnt[i] + 1`.
  - If `sync[i] == stable[i]`: `cnt[i] <= 0`. `glitch[i] <= (cnt[i] != 0)`.
- Comparison uses `>=`, not `==`. If `filter_len` shrinks mid-count, the update fires on the next mismatching edge. The counter therefore never wraps.
- Bypass (`bypass[i] = 1`):
  - `stable[i] <= sync[i]` every edge.
  - `cnt[i] <= 0`.
  - `glitch[i] <= 0`.
- Bypass toggling mid-count:
  - Entering bypass discards the count with no glitch pulse.
  - Leaving bypass restarts the count from 0.
- `glitch` is registered and asserts for exactly one cycle per rejected change. It is a diagnostic only and does not reach the PLIC.
- Sources are fully independent. Any combination of simultaneous changes behaves per-source exactly as a single change would.
- Reset, whether asserted at start-up or mid-operation, asynchronously clears everything:
  - All synchronizer flops, `stable`, `cnt` and `glitch` go to 0.
  - As a result, `src_out = 0` and `glitch = 0`.
  - An in-flight count is lost.
  - After release, a line held high appears at `src_out` `SYNC_STAGES + L` edges later.

## Timing
- Reference point: a change on `src_in` that is set up before edge 1 is visible at `sync` after edge `S = SYNC_STAGES`.
- Non-bypassed latency: `src_out` changes at edge `S + L`, provided the input is held through edge `S + L - 1` at the synchronizer input.
- Bypassed latency: `src_out` changes at edge `S + 1`.
- Pulse filtering: a pulse shorter than `L` cycles at `sync` never reaches `src_out`. `glitch` pulses for one cycle, on the edge after `sync` returns to its old value.
- Pulse passing: a pulse of `P >= L` cycles reaches `src_out` delayed and stretched/shrunk to exactly `P` cycles, because both edges see the same latency.
- Asynchronous inputs carry ±1 cycle of uncertainty at the synchronizer input. Nothing is guaranteed beyond that.

## Test plan
- Reset: hold `src_in = all 1s` with `rst = 1`. Then `src_out = 0` and `glitch = 0`. Release at edge 0 with `SYNC_STAGES = 2` and `filter_len = 4`: `src_out` goes to all 1s at edge 6.
- Debounce pass: source 3, `filter_len = 5`, a 0→1 step before edge 1. `src_out[3]` rises at edge 7. A later 1→0 step falls with the same 7-edge latency.
- Glitch rejection: `filter_len = 5`, a 3-cycle high pulse on source 0. `src_out[0]` stays 0 throughout. `glitch[0]` is high for exactly one cycle, at edge 6.
- Bypass and zero length: `bypass[1] = 1` with a 1-cycle pulse gives `src_out[1]` high for 1 cycle at edge 3. `filter_len = 0` and `filter_len = 1` with a step on source 2 both rise at edge 3.
- `filter_len` shrink: `filter_len = 10`, step on source 5. At `cnt = 6`, write `filter_len = 3`. `src_out[5]` updates on the next edge and the counter returns to 0.
- Simultaneous sources and mid-count reset: step all 64 lines with `filter_len = 4`. All rise on the same edge. Assert `rst` for 1 cycle mid-count: all outputs are 0, and the lines rise again 6 edges after release.

Source files
------------

// File: rtl/iob_plic_src_filter.sv
// iob_plic_src_filter: per-source synchronizer + debounce for PLIC inputs; in src_in/bypass/filter_len, out src_out/glitch
module iob_plic_src_filter #(
  parameter int SOURCES     = 64,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SOURCES-1:0]  src_in,
  input  logic [SOURCES-1:0]  bypass,
  input  logic [FILTER_W-1:0] filter_len,
  output logic [SOURCES-1:0]  src_out,
  output logic [SOURCES-1:0]  glitch
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be 2..4");
  end
  logic [FILTER_W:0] len_eff;
  assign len_eff = {1'b0, (filter_len == '0) ? FILTER_W'(1) : filter_len};
  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    logic [SYNC_STAGES-1:0] chain;
    logic [FILTER_W-1:0]    cnt, cnt_nx;
    logic                   stable, glitch_q;
    logic                   sync, diff, fire, stable_nx, glitch_nx;
    always_comb begin
      sync      = chain[SYNC_STAGES-1];
      diff      = sync != stable;
      fire      = diff && (({1'b0, cnt} + (FILTER_W+1)'(1)) >= len_eff);
      stable_nx = (bypass[i] || fire) ? sync : stable;
      cnt_nx    = (bypass[i] || !diff || fire) ? '0 : cnt + FILTER_W'(1);
      glitch_nx = !bypass[i] && !diff && (cnt != '0);
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        chain    <= '0;
        stable   <= 1'b0;
        cnt      <= '0;
        glitch_q <= 1'b0;
      end else begin
        chain    <= {chain[SYNC_STAGES-2:0], src_in[i]};
        stable   <= stable_nx;
        cnt      <= cnt_nx;
        glitch_q <= glitch_nx;
      end
    assign src_out[i] = stable;
    assign glitch[i]  = glitch_q;
  end
endmodule

// File: tb/tb_iob_plic_src_filter.sv
// tb_iob_plic_src_filter: directed bench with behavioural model and literal edge-count checks
module tb_iob_plic_src_filter;
  localparam int N = 64;
  localparam int S = 2;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] src_in = '0;
  logic [N-1:0] bypass = '0;
  logic [W-1:0] filter_len = '0;
  logic [N-1:0] src_out, glitch;
  int tests = 0;
  int fails = 0;
  iob_plic_src_filter #(.SOURCES(N), .SYNC_STAGES(S), .FILTER_W(W)) dut (
    .clk(clk), .rst(rst), .src_in(src_in), .bypass(bypass),
    .filter_len(filter_len), .src_out(src_out), .glitch(glitch)
  );
  always #5 clk = ~clk;
  logic [N-1:0] hist [S];
  logic [N-1:0] out_m = '0;
  logic [N-1:0] gl_m = '0;
  int           run [N];
  task automatic step();
    logic [N-1:0] sy;
    int l;
    if (rst) begin
      out_m = '0;
      gl_m  = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
      for (int k = 0; k < S; k++) hist[k] = '0;
      return;
    end
    sy = hist[S-1];
    l  = (filter_len == 0) ? 1 : int'(filter_len);
    for (int i = 0; i < N; i++) begin
      gl_m[i] = 1'b0;
      if (bypass[i]) begin
        out_m[i] = sy[i];
        run[i]   = 0;
      end else if (sy[i] != out_m[i]) begin
        run[i] = run[i] + 1;
        if (run[i] >= l) begin
          out_m[i] = sy[i];
          run[i]   = 0;
        end
      end else begin
        gl_m[i] = (run[i] != 0);
        run[i]  = 0;
      end
    end
    for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = src_in;
  endtask
  initial begin
    for (int k = 0; k < S; k++) hist[k] = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      step();
    end
  end
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    #2;
    chk("model_src_out", src_out, out_m);
    chk("model_glitch", glitch, gl_m);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    src_in = '1;
    filter_len = 8'd4;
    rst = 1'b1;
    tick(3);
    chk("rst_src_out", src_out, '0);
    chk("rst_glitch", glitch, '0);
    rst = 1'b0;
    tick(5); chk("rel_e5", src_out, '0);
    tick(1); chk("rel_e6", src_out, '1);
    src_in = '0;
    tick(10); chk("cleared", src_out, '0);
    filter_len = 8'd5;
    src_in[3] = 1'b1;
    tick(6); chk("db_rise_e6", N'(src_out[3]), N'(0));
    tick(1); chk("db_rise_e7", N'(src_out[3]), N'(1));
    tick(5);
    src_in[3] = 1'b0;
    tick(6); chk("db_fall_e6", N'(src_out[3]), N'(1));
    tick(1); chk("db_fall_e7", N'(src_out[3]), N'(0));
    tick(5);
    src_in[0] = 1'b1;
    tick(3);
    src_in[0] = 1'b0;
    tick(2); chk("gl_e5", N'(glitch[0]), N'(0));
    tick(1); chk("gl_e6", N'(glitch[0]), N'(1));
    chk("gl_out_low", N'(src_out[0]), N'(0));
    tick(1); chk("gl_e7", N'(glitch[0]), N'(0));
    tick(3);
    bypass[1] = 1'b1;
    tick(3);
    src_in[1] = 1'b1;
    tick(1);
    src_in[1] = 1'b0;
    tick(1); chk("byp_e2", N'(src_out[1]), N'(0));
    tick(1); chk("byp_e3", N'(src_out[1]), N'(1));
    tick(1); chk("byp_e4", N'(src_out[1]), N'(0));
    tick(3);
    bypass[1] = 1'b0;
    filter_len = 8'd0;
    src_in[2] = 1'b1;
    tick(2); chk("len0_e2", N'(src_out[2]), N'(0));
    tick(1); chk("len0_e3", N'(src_out[2]), N'(1));
    src_in[2] = 1'b0;
    tick(6);
    filter_len = 8'd1;
    src_in[2] = 1'b1;
    tick(2); chk("len1_e2", N'(src_out[2]), N'(0));
    tick(1); chk("len1_e3", N'(src_out[2]), N'(1));
    src_in[2] = 1'b0;
    tick(6);
    filter_len = 8'd10;
    src_in[5] = 1'b1;
    tick(8); chk("shrink_e8", N'(src_out[5]), N'(0));
    filter_len = 8'd3;
    tick(1); chk("shrink_e9", N'(src_out[5]), N'(1));
    src_in[5] = 1'b0;
    tick(8);
    filter_len = 8'd4;
    src_in = '1;
    tick(5); chk("all_e5", src_out, '0);
    tick(1); chk("all_e6", src_out, '1);
    src_in = '0;
    tick(8); chk("all_fall", src_out, '0);
    src_in = '1;
    tick(4);
    rst = 1'b1;
    #1;
    chk("midrst_out", src_out, '0);
    chk("midrst_glitch", glitch, '0);
    tick(1);
    rst = 1'b0;
    tick(5); chk("rerise_e5", src_out, '0);
    tick(1); chk("rerise_e6", src_out, '1);
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
